// File: rtl/ff_conv_pkg.sv
// JK command encodings and cell helpers shared by the flip-flop conversion blocks.
package ff_conv_pkg;

   typedef logic [1:0] jk_cmd_t;

   localparam jk_cmd_t JK_HOLD = 2'b00;
   localparam jk_cmd_t JK_RST  = 2'b01;
   localparam jk_cmd_t JK_SET  = 2'b10;
   localparam jk_cmd_t JK_TGL  = 2'b11;

   // Next state of a JK cell for command {j,k} and present state q.
   function automatic logic jk_next(input jk_cmd_t cmd, input logic q);
      logic nq;
      case (cmd)
         JK_HOLD: nq = q;
         JK_RST:  nq = 1'b0;
         JK_SET:  nq = 1'b1;
         JK_TGL:  nq = ~q;
         default: nq = q;
      endcase
      return nq;
   endfunction

   // D-style load: J=d, K=~d.
   function automatic jk_cmd_t jk_load_cmd(input logic d);
      return {d, ~d};
   endfunction

   // T-style operation: J=K=t.
   function automatic jk_cmd_t jk_toggle_cmd(input logic t);
      return {t, t};
   endfunction

endpackage

// File: rtl/t_using_jk_counter_jk_ff.sv
// Single JK flip-flop cell with asynchronous active-high reset to q=0, qb=1.
module jk_ff
   import ff_conv_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qb
);

   logic q_q;
   logic q_d;

   // Next-state decode of the JK command.
   always_comb begin
      q_d = jk_next({j, k}, q_q);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q  = q_q;
   assign qb = ~q_q;

endmodule

// File: rtl/t_using_jk_counter.sv
// Up/down binary counter composed of JK cells, with combinational terminal
// count and a registered one-cycle wrap pulse.
module t_using_jk_counter
   import ff_conv_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc,
   output logic             wrap
);

   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] qb_s;
   logic [WIDTH-1:0] t_s;
   logic [WIDTH-1:0] j_s;
   logic [WIDTH-1:0] k_s;
   logic             tc_s;
   logic             wrap_q;
   logic             wrap_d;

   // Toggle enables: bit i flips once all lower bits are 1 (up) or 0 (down).
   always_comb begin
      logic up_run;
      logic dn_run;
      t_s    = '0;
      up_run = 1'b1;
      dn_run = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         if (up) begin
            t_s[i] = up_run;
         end else begin
            t_s[i] = dn_run;
         end
         up_run = up_run & q_s[i];
         dn_run = dn_run & qb_s[i];
      end
   end

   // J/K steering: load beats count, count beats hold.
   always_comb begin
      j_s = '0;
      k_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (load) begin
            {j_s[i], k_s[i]} = jk_load_cmd(din[i]);
         end else if (en) begin
            {j_s[i], k_s[i]} = jk_toggle_cmd(t_s[i]);
         end else begin
            {j_s[i], k_s[i]} = JK_HOLD;
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_cell
         jk_ff u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_s[g]),
            .k   (k_s[g]),
            .q   (q_s[g]),
            .qb  (qb_s[g])
         );
      end
   endgenerate

   // Terminal count: the coming edge rolls the counter over.
   always_comb begin
      if (load || !en) begin
         tc_s = 1'b0;
      end else if (up) begin
         tc_s = &q_s;
      end else begin
         tc_s = ~(|q_s);
      end
   end

   // Wrap pulse follows tc by one edge.
   always_comb begin
      wrap_d = tc_s;
   end

   // Wrap register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign q    = q_s;
   assign qb   = qb_s;
   assign tc   = tc_s;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_t_using_jk_counter.sv
// Scoreboard bench for t_using_jk_counter (WIDTH=4): driver queues expected
// state, a monitor pops and compares at negedges or on async-reset probes.
module tb_t_using_jk_counter;

   typedef struct {
      string      name;
      logic [3:0] q;
      logic       tc;
      logic       wrap;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] din;
   logic [3:0] q;
   logic [3:0] qb;
   logic       tc;
   logic       wrap;

   exp_t sb[$];
   int   checks;
   int   failures;
   event chk_ev;

   t_using_jk_counter #(.WIDTH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .up   (up),
      .load (load),
      .din  (din),
      .q    (q),
      .qb   (qb),
      .tc   (tc),
      .wrap (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input string what, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s.%s actual=%h required=%h @%0t", name, what, act, req, $time);
      end
   endtask

   task automatic push(input string name, input logic [3:0] eq, input logic etc, input logic ewrap);
      exp_t e;
      e.name = name;
      e.q    = eq;
      e.tc   = etc;
      e.wrap = ewrap;
      sb.push_back(e);
   endtask

   // After the edge: apply next inputs, then queue the state seen this cycle.
   task automatic step(input string name, input logic l, input logic e, input logic u,
                       input logic [3:0] d, input logic [3:0] eq, input logic etc, input logic ewrap);
      @(posedge clk);
      #1;
      load = l;
      en   = e;
      up   = u;
      din  = d;
      push(name, eq, etc, ewrap);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or chk_ev);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.name, "q", q, e.q);
            cmp(e.name, "qb", qb, ~e.q);
            cmp(e.name, "tc", {3'b000, tc}, {3'b000, e.tc});
            cmp(e.name, "wrap", {3'b000, wrap}, {3'b000, e.wrap});
         end
      end
   end

   // Watchdog
   initial begin
      #20000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   // Driver
   initial begin
      logic [3:0] uq;
      int         wait_cnt;
      checks   = 0;
      failures = 0;
      rst  = 1'b1;
      en   = 1'b1;
      up   = 1'b1;
      load = 1'b0;
      din  = 4'h0;

      #1;
      push("reset0", 4'h0, 1'b0, 1'b0);
      #10;
      push("reset1", 4'h0, 1'b0, 1'b0);
      #10;
      rst = 1'b0;

      for (int k = 1; k <= 17; k++) begin
         uq = 4'(k);
         step("up", 1'b0, 1'b1, 1'b1, 4'h0, uq, (uq == 4'hF), (k == 16));
      end

      step("load2",  1'b1, 1'b1, 1'b0, 4'h2, 4'h2, 1'b0, 1'b0);
      step("dn2",    1'b0, 1'b1, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0);
      step("dn1",    1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0);
      step("dn0",    1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
      step("dn15",   1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1);
      step("dn14",   1'b0, 1'b1, 1'b1, 4'h0, 4'hE, 1'b0, 1'b0);
      step("ldpri",  1'b1, 1'b1, 1'b1, 4'hA, 4'hF, 1'b0, 1'b0);
      step("ldA",    1'b1, 1'b0, 1'b0, 4'h7, 4'hA, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step("hold", 1'b0, 1'b0, k[0], 4'h0, 4'h7, 1'b0, 1'b0);
      end
      step("hold_end", 1'b1, 1'b0, 1'b0, 4'h9, 4'h7, 1'b0, 1'b0);
      step("q9",       1'b0, 1'b1, 1'b1, 4'h0, 4'h9, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      push("async_rst", 4'h0, 1'b0, 1'b0);
      -> chk_ev;
      @(posedge clk);
      #1;
      push("rst_hold", 4'h0, 1'b0, 1'b0);
      rst  = 1'b0;
      load = 1'b1;
      din  = 4'hF;

      step("q15",     1'b0, 1'b1, 1'b1, 4'h0, 4'hF, 1'b1, 1'b0);
      step("wrap_up", 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      push("wrap_clr", 4'h0, 1'b0, 1'b0);
      -> chk_ev;
      @(posedge clk);
      #1;
      rst = 1'b0;
      push("post_rst", 4'h0, 1'b0, 1'b0);

      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 20) begin
         @(negedge clk);
         #1;
         wait_cnt++;
      end
      if (sb.size() > 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0 pending entries", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
